assist_sequencer: RTL and testbench
===================================

// Module: assist_sequencer
// PURPOSE
//  Sequences the assistance torque path. Takes the raw assistance target from the assistance calculator
//  and issues a slew-limited motor command: soft-start, tracking, soft-stop, brake cut and tilt lockout.
//  Sits between the assistance calculator and the current control module.
// PARAMETERS
//  TICK_DIV               50000  clk cycles per update tick (1 kHz at 50 MHz)
//  RAMP_STEP              16     max command increase/decrease per tick (LSB of 13-bit command)
//  CADENCE_TIMEOUT_TICKS  1000   ticks without a cadence edge before rider counts as not pedaling
//  TILT_LIMIT             45     |roll| or |pitch| at or above this value is a tilt fault (degrees)
//  FAULT_HOLD_TICKS       2000   ticks tilt must stay clear before FAULT exits
// PORTS
//  clk                 in   1   system clock
//  reset               in   1   asynchronous, active-high reset
//  AssistanceRequest   in   13  unsigned target from assistance calculator
//  ResolvedRoll        in   10  signed roll, degrees
//  ResolvedPitch       in   10  signed pitch, degrees
//  cadence             in   1   async pedal pulse; a rising edge marks one stroke
//  brake               in   1   brake lever, active high, already synchronous
//  enable              in   1   rider assist enable from cellphone
//  fault_clear         in   1   one-clk pulse that acknowledges a latched fault (FAULT_LATCH_EN only)
//  MotorCommand        out  13  slew-limited command to current control
//  MotorEnable         out  1   high in RAMP_UP/TRACK/RAMP_DOWN
//  AssistState         out  3   current state (assist_state_t)
//  fault               out  1   high while in FAULT
// BEHAVIOUR
//  Reset: MotorCommand=0, MotorEnable=0, AssistState=OFF, fault=0, all counters/sync flops 0; async, takes effect mid-operation.
//  Tick: prescaler counts 0..TICK_DIV-1; one-clk tick pulse on wrap. Ramp arithmetic updates only on tick.
//  Cadence: 2-FF sync + rising-edge detect. Each edge clears the stroke timer; the timer counts ticks and
//    saturates at CADENCE_TIMEOUT_TICKS. pedaling = timer < CADENCE_TIMEOUT_TICKS. An edge and a tick in the same clk: the edge wins.
//  Tilt: abs() of roll/pitch; -512 saturates to 511. tilt = absRoll>=TILT_LIMIT || absPitch>=TILT_LIMIT.
//  Priority, evaluated every clk, not tick-gated: tilt > brake > state logic.
//    tilt from any state -> FAULT next clk; MotorCommand=0, MotorEnable=0 in that same update.
//    brake (no tilt) -> OFF next clk, MotorCommand=0. Brake and tick in the same clk: brake wins.
//  States (assist_state_t): OFF, RAMP_UP, TRACK, RAMP_DOWN, FAULT.
//    OFF:       cmd=0. On tick with enable && pedaling && target>0 -> RAMP_UP.
//    RAMP_UP:   per tick cmd += min(RAMP_STEP, target-cmd). cmd reaches target, or target<=cmd -> TRACK.
//               Loss of enable or pedaling -> RAMP_DOWN.
//    TRACK:     per tick a rising target is limited to +RAMP_STEP; a falling target is applied at once (cmd=target).
//               Loss of enable or pedaling -> RAMP_DOWN.
//    RAMP_DOWN: per tick cmd -= min(RAMP_STEP, cmd). cmd==0 -> OFF. enable && pedaling return -> RAMP_UP.
//    FAULT:     cmd=0; the hold counter counts ticks while !tilt and clears whenever tilt is seen.
//               Exit to OFF once the hold counter reaches FAULT_HOLD_TICKS.
//  Arithmetic: 14-bit sum; clamp to 8191. Target is unsigned; upstream already clamps negative values to 0.
//  Latency: brake/tilt to zero command = 1 clk. Ramp step = 1 clk after tick.
// CONFIGURATION
//  FAULT_LATCH_EN defined: FAULT additionally requires a fault_clear pulse after hold expiry.
//    A fault_clear pulse before expiry is ignored and is not remembered.
//  FAULT_LATCH_EN undefined: fault_clear is ignored and FAULT exits on hold expiry alone. The port is present in both builds.
// STRUCTURE
//  assist_pkg: assist_state_t enum (3-bit), CMD_W=13, ANGLE_W=10, CMD_MAX=13'd8191.
//  Sub-module cadence_monitor: sync, edge detect and stroke timer; outputs pedaling.
//  Tick prescaler, tilt compare, FSM and ramp stay in assist_sequencer.
// TESTING  (TICK_DIV=4, RAMP_STEP=16, CADENCE_TIMEOUT_TICKS=8, FAULT_HOLD_TICKS=4)
//  1. enable=1, cadence edge every 3 ticks, target=100 -> cmd 16,32,48,64,80,96,100 on successive ticks, then TRACK.
//  2. TRACK cmd=100, brake=1 -> next clk cmd=0, MotorEnable=0, state OFF; stays OFF while brake is held.
//  3. ResolvedRoll=-50 in TRACK -> next clk FAULT, fault=1, cmd=0. Roll=0 -> OFF after 4 ticks.
//     With FAULT_LATCH_EN: stays in FAULT until a fault_clear pulse after the 4 ticks.
//  4. TRACK cmd=100, cadence stops -> after 8 ticks RAMP_DOWN; cmd 84,68,52,36,20,4,0, then OFF.
//  5. TRACK cmd=100, target->40 -> cmd=40 on next tick. Target->200 -> cmd 56,72,... +16/tick up to 200.
//  6. ResolvedPitch=-512 -> abs 511 -> FAULT. Assert reset mid RAMP_UP -> cmd=0, state OFF immediately, no clk edge needed.

Source files
------------

// File: rtl/assist_pkg.sv
// Shared widths, limits and state encoding for the assist torque sequencer.
package assist_pkg;

   localparam int CMD_W   = 13;
   localparam int ANGLE_W = 10;
   localparam logic [CMD_W-1:0] CMD_MAX = 13'd8191;

   typedef enum logic [2:0] {
      OFF       = 3'd0,
      RAMP_UP   = 3'd1,
      TRACK     = 3'd2,
      RAMP_DOWN = 3'd3,
      FAULT     = 3'd4
   } assist_state_t;

   // Magnitude of a signed angle; -512 has no positive twin and saturates to 511.
   function automatic logic [ANGLE_W-1:0] angle_abs(input logic [ANGLE_W-1:0] a);
      logic [ANGLE_W-1:0] neg;
      neg = -a;
      if (!a[ANGLE_W-1])
         return a;
      else if (a == {1'b1, {(ANGLE_W-1){1'b0}}})
         return {1'b0, {(ANGLE_W-1){1'b1}}};
      else
         return neg;
   endfunction

endpackage

// File: rtl/cadence_monitor.sv
// Pedal cadence monitor: synchronises the raw pedal pulse, detects strokes and
// flags the rider as pedaling until TIMEOUT_TICKS ticks pass without a stroke.
module cadence_monitor #(
   parameter int TIMEOUT_TICKS = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic cadence,
   input  logic tick,
   output logic pedaling
);

   localparam int TW = $clog2(TIMEOUT_TICKS + 1);
   localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT_TICKS);

   logic [1:0]    sync_reg;
   logic          prev_reg;
   logic [TW-1:0] timer_reg;
   logic          stroke;

   assign stroke = sync_reg[1] & ~prev_reg;

   // A stroke clears the timer even when it coincides with a tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_reg  <= '0;
         prev_reg  <= 1'b0;
         timer_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[0], cadence};
         prev_reg <= sync_reg[1];
         if (stroke)
            timer_reg <= '0;
         else if (tick && (timer_reg < TIMEOUT_V))
            timer_reg <= timer_reg + TW'(1);
      end
   end

   assign pedaling = (timer_reg < TIMEOUT_V);

endmodule

// File: rtl/assist_sequencer.sv
// Assist torque sequencer: slew-limited motor command with soft start/stop, brake cut and tilt lockout.
// Build option FAULT_LATCH_EN: leaving FAULT also needs a fault_clear pulse after the hold expires.
module assist_sequencer
   import assist_pkg::*;
#(
   parameter int TICK_DIV              = 50000,
   parameter int RAMP_STEP             = 16,
   parameter int CADENCE_TIMEOUT_TICKS = 1000,
   parameter int TILT_LIMIT            = 45,
   parameter int FAULT_HOLD_TICKS      = 2000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CMD_W-1:0]   AssistanceRequest,
   input  logic [ANGLE_W-1:0] ResolvedRoll,
   input  logic [ANGLE_W-1:0] ResolvedPitch,
   input  logic               cadence,
   input  logic               brake,
   input  logic               enable,
   input  logic               fault_clear,
   output logic [CMD_W-1:0]   MotorCommand,
   output logic               MotorEnable,
   output logic [2:0]         AssistState,
   output logic               fault
);

   localparam int DIV_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int HOLD_W = $clog2(FAULT_HOLD_TICKS + 1);
   localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [HOLD_W-1:0]  HOLD_V   = HOLD_W'(FAULT_HOLD_TICKS);
   localparam logic [CMD_W-1:0]   STEP_V   = CMD_W'(RAMP_STEP);
   localparam logic [ANGLE_W-1:0] TILT_V   = ANGLE_W'(TILT_LIMIT);

   logic [DIV_W-1:0]  div_reg;
   logic              tick;
   assist_state_t     state_reg, state_next;
   logic [CMD_W-1:0]  cmd_reg, cmd_next, up_cmd, down_cmd;
   logic [CMD_W:0]    up_sum;
   logic [HOLD_W-1:0] hold_reg, hold_next;
   logic              pedaling, tilt, assist_ok, hold_done, release_ok;

   assign tick = (div_reg == DIV_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         div_reg <= '0;
      else if (tick)
         div_reg <= '0;
      else
         div_reg <= div_reg + DIV_W'(1);
   end

   cadence_monitor #(
      .TIMEOUT_TICKS(CADENCE_TIMEOUT_TICKS)
   ) u_cadence (
      .clk     (clk),
      .reset   (reset),
      .cadence (cadence),
      .tick    (tick),
      .pedaling(pedaling)
   );

   assign tilt = (angle_abs(ResolvedRoll) >= TILT_V) || (angle_abs(ResolvedPitch) >= TILT_V);
   assign assist_ok = enable && pedaling;
   assign hold_done = (hold_reg == HOLD_V);

`ifdef FAULT_LATCH_EN
   assign release_ok = hold_done && fault_clear;
`else
   logic unused_fault_clear;
   assign unused_fault_clear = fault_clear;
   assign release_ok = hold_done;
`endif

   // Candidate one-tick moves; the up move never overshoots the target nor wraps past CMD_MAX.
   always_comb begin
      up_sum = {1'b0, cmd_reg} + {1'b0, STEP_V};
      up_cmd = (up_sum > {1'b0, CMD_MAX}) ? CMD_MAX : up_sum[CMD_W-1:0];
      if (up_cmd > AssistanceRequest)
         up_cmd = AssistanceRequest;
      down_cmd = (cmd_reg > STEP_V) ? (cmd_reg - STEP_V) : '0;
   end

   always_comb begin
      state_next = state_reg;
      cmd_next   = cmd_reg;
      hold_next  = '0;
      if (tilt) begin
         state_next = FAULT;
         cmd_next   = '0;
      end else if (brake) begin
         state_next = OFF;
         cmd_next   = '0;
      end else begin
         case (state_reg)
            OFF: begin
               cmd_next = '0;
               if (tick && assist_ok && (AssistanceRequest != '0))
                  state_next = RAMP_UP;
            end
            RAMP_UP: if (tick) begin
               if (!assist_ok)
                  state_next = RAMP_DOWN;
               else if (AssistanceRequest <= cmd_reg)
                  state_next = TRACK;
               else begin
                  cmd_next = up_cmd;
                  if (up_cmd == AssistanceRequest)
                     state_next = TRACK;
               end
            end
            TRACK: if (tick) begin
               if (!assist_ok)
                  state_next = RAMP_DOWN;
               else if (AssistanceRequest < cmd_reg)
                  cmd_next = AssistanceRequest;
               else
                  cmd_next = up_cmd;
            end
            RAMP_DOWN: if (tick) begin
               if (assist_ok)
                  state_next = RAMP_UP;
               else begin
                  cmd_next = down_cmd;
                  if (down_cmd == '0)
                     state_next = OFF;
               end
            end
            FAULT: begin
               cmd_next  = '0;
               hold_next = hold_reg;
               if (release_ok) begin
                  state_next = OFF;
                  hold_next  = '0;
               end else if (tick && !hold_done)
                  hold_next = hold_reg + HOLD_W'(1);
            end
            default: begin
               state_next = OFF;
               cmd_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= OFF;
         cmd_reg   <= '0;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cmd_reg   <= cmd_next;
         hold_reg  <= hold_next;
      end
   end

   assign MotorCommand = cmd_reg;
   assign MotorEnable  = (state_reg == RAMP_UP) || (state_reg == TRACK) || (state_reg == RAMP_DOWN);
   assign AssistState  = state_reg;
   assign fault        = (state_reg == FAULT);

endmodule

// File: tb/tb_assist_sequencer.sv
// Scenario bench for assist_sequencer with small tick/timeout parameters; honours FAULT_LATCH_EN.
module tb_assist_sequencer;
   import assist_pkg::*;

   localparam int TDIV = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [12:0] AssistanceRequest = '0;
   logic [9:0]  ResolvedRoll = '0;
   logic [9:0]  ResolvedPitch = '0;
   logic        cadence = 1'b0;
   logic        brake = 1'b0;
   logic        enable = 1'b0;
   logic        fault_clear = 1'b0;
   logic [12:0] MotorCommand;
   logic        MotorEnable;
   logic [2:0]  AssistState;
   logic        fault;

   int total = 0;
   int bad = 0;
   int unsigned cyc;
   bit cad_auto = 1'b0;

   typedef struct packed {
      logic [2:0]  st;
      logic [12:0] cmd;
   } exp_t;
   exp_t exp_q[$];
   exp_t e;

   assist_sequencer #(
      .TICK_DIV(TDIV), .RAMP_STEP(16), .CADENCE_TIMEOUT_TICKS(8),
      .TILT_LIMIT(45), .FAULT_HOLD_TICKS(4)
   ) dut (
      .clk(clk), .reset(reset), .AssistanceRequest(AssistanceRequest),
      .ResolvedRoll(ResolvedRoll), .ResolvedPitch(ResolvedPitch), .cadence(cadence),
      .brake(brake), .enable(enable), .fault_clear(fault_clear),
      .MotorCommand(MotorCommand), .MotorEnable(MotorEnable),
      .AssistState(AssistState), .fault(fault)
   );

   always #5 clk = ~clk;

   always @(posedge clk or posedge reset) begin
      if (reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   // Background pedal: one short pulse every 12 clocks while cad_auto is set.
   initial begin
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk); #2;
         if (cad_auto) begin
            cnt++;
            if (cnt == 12) begin cnt = 0; cadence = 1'b1; end
            else if (cnt == 2) cadence = 1'b0;
         end else begin
            cadence = 1'b0;
         end
      end
   end

   function automatic exp_t mk(input logic [2:0] st, input int cmd);
      mk.st = st;
      mk.cmd = 13'(cmd);
   endfunction

   task automatic next_tick();
      bit tk;
      for (int i = 0; i < 2 * TDIV; i++) begin
         tk = (cyc % TDIV == TDIV - 1);
         @(posedge clk); #1;
         if (tk) return;
      end
      total++; bad++;
      $display("FAIL tick_wait: got no tick within %0d clks, required one", 2 * TDIV);
   endtask

   task automatic go_track(input int target);
      AssistanceRequest = 13'(target);
      for (int i = 0; i < 40; i++) begin
         next_tick();
         if (AssistState == TRACK) break;
      end
      total++;
      if (AssistState !== TRACK || MotorCommand !== 13'(target)) begin
         bad++;
         $display("FAIL go_track: got st=%0d cmd=%0d required st=%0d cmd=%0d",
                  AssistState, MotorCommand, TRACK, target);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (MotorCommand !== 13'd0 || MotorEnable !== 1'b0 || AssistState !== OFF || fault !== 1'b0) begin
         bad++;
         $display("FAIL reset_state: got cmd=%0d en=%0b st=%0d fault=%0b required 0/0/%0d/0",
                  MotorCommand, MotorEnable, AssistState, fault, OFF);
      end
      #4 reset = 1'b0;
   endtask

   task automatic test_ramp_up();
      enable = 1'b1;
      cad_auto = 1'b1;
      AssistanceRequest = 13'd100;
      exp_q.push_back(mk(RAMP_UP, 0));
      for (int c = 16; c <= 96; c += 16) exp_q.push_back(mk(RAMP_UP, c));
      exp_q.push_back(mk(TRACK, 100));
      exp_q.push_back(mk(TRACK, 100));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         next_tick();
         total++;
         if (MotorCommand !== e.cmd || AssistState !== e.st) begin
            bad++;
            $display("FAIL ramp_up: got cmd=%0d st=%0d required cmd=%0d st=%0d",
                     MotorCommand, AssistState, e.cmd, e.st);
         end
      end
   endtask

   task automatic test_track();
      AssistanceRequest = 13'd40;
      exp_q.push_back(mk(TRACK, 40));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         next_tick();
         total++;
         if (MotorCommand !== e.cmd || AssistState !== e.st) begin
            bad++;
            $display("FAIL track_fall: got cmd=%0d st=%0d required cmd=%0d st=%0d",
                     MotorCommand, AssistState, e.cmd, e.st);
         end
      end
      AssistanceRequest = 13'd200;
      for (int c = 56; c <= 200; c += 16) exp_q.push_back(mk(TRACK, c));
      exp_q.push_back(mk(TRACK, 200));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         next_tick();
         total++;
         if (MotorCommand !== e.cmd || AssistState !== e.st) begin
            bad++;
            $display("FAIL track_rise: got cmd=%0d st=%0d required cmd=%0d st=%0d",
                     MotorCommand, AssistState, e.cmd, e.st);
         end
      end
      AssistanceRequest = 13'd100;
      next_tick();
   endtask

   task automatic test_brake();
      brake = 1'b1;
      @(posedge clk); #1;
      total++;
      if (MotorCommand !== 13'd0 || MotorEnable !== 1'b0 || AssistState !== OFF) begin
         bad++;
         $display("FAIL brake_cut: got cmd=%0d en=%0b st=%0d required 0/0/%0d",
                  MotorCommand, MotorEnable, AssistState, OFF);
      end
      for (int i = 0; i < 2; i++) begin
         next_tick();
         total++;
         if (MotorCommand !== 13'd0 || AssistState !== OFF) begin
            bad++;
            $display("FAIL brake_hold: got cmd=%0d st=%0d required 0/%0d",
                     MotorCommand, AssistState, OFF);
         end
      end
      brake = 1'b0;
      go_track(100);
   endtask

   task automatic test_tilt();
      ResolvedRoll = 10'd44;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (AssistState !== TRACK || fault !== 1'b0) begin
         bad++;
         $display("FAIL tilt_below_limit: got st=%0d fault=%0b required %0d/0", AssistState, fault, TRACK);
      end
      ResolvedRoll = -10'sd50;
      @(posedge clk); #1;
      total++;
      if (AssistState !== FAULT || fault !== 1'b1 || MotorCommand !== 13'd0 || MotorEnable !== 1'b0) begin
         bad++;
         $display("FAIL tilt_enter: got st=%0d fault=%0b cmd=%0d en=%0b required %0d/1/0/0",
                  AssistState, fault, MotorCommand, MotorEnable, FAULT);
      end
      ResolvedRoll = '0;
      for (int i = 1; i <= 4; i++) begin
         next_tick();
         total++;
         if (AssistState !== FAULT) begin
            bad++;
            $display("FAIL tilt_hold_%0d: got st=%0d required %0d", i, AssistState, FAULT);
         end
`ifdef FAULT_LATCH_EN
         if (i == 2) begin
            fault_clear = 1'b1;
            @(posedge clk); #1;
            fault_clear = 1'b0;
         end
`endif
      end
      @(posedge clk); #1;
`ifdef FAULT_LATCH_EN
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (AssistState !== FAULT) begin
         bad++;
         $display("FAIL tilt_latched: got st=%0d required %0d", AssistState, FAULT);
      end
      fault_clear = 1'b1;
      @(posedge clk); #1;
      fault_clear = 1'b0;
`endif
      total++;
      if (AssistState !== OFF || fault !== 1'b0) begin
         bad++;
         $display("FAIL tilt_exit: got st=%0d fault=%0b required %0d/0", AssistState, fault, OFF);
      end
      go_track(100);
   endtask

   task automatic test_cadence_loss();
      int n;
      cad_auto = 1'b0;
      n = 0;
      while (AssistState == TRACK && n < 16) begin
         next_tick();
         n++;
      end
      total++;
      if (AssistState !== RAMP_DOWN || MotorCommand !== 13'd100 || n < 5 || n > 10) begin
         bad++;
         $display("FAIL cadence_timeout: got st=%0d cmd=%0d after %0d ticks required %0d/100 after 5..10",
                  AssistState, MotorCommand, n, RAMP_DOWN);
      end
      for (int c = 84; c > 0; c -= 16) exp_q.push_back(mk(RAMP_DOWN, c));
      exp_q.push_back(mk(OFF, 0));
      exp_q.push_back(mk(OFF, 0));
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         next_tick();
         total++;
         if (MotorCommand !== e.cmd || AssistState !== e.st) begin
            bad++;
            $display("FAIL ramp_down: got cmd=%0d st=%0d required cmd=%0d st=%0d",
                     MotorCommand, AssistState, e.cmd, e.st);
         end
      end
   endtask

   task automatic test_pitch_and_reset();
      int n;
      cad_auto = 1'b1;
      ResolvedPitch = 10'h200;
      @(posedge clk); #1;
      total++;
      if (AssistState !== FAULT || fault !== 1'b1) begin
         bad++;
         $display("FAIL pitch_min: got st=%0d fault=%0b required %0d/1", AssistState, fault, FAULT);
      end
      ResolvedPitch = '0;
`ifdef FAULT_LATCH_EN
      fault_clear = 1'b1;
`endif
      n = 0;
      while (AssistState != OFF && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      fault_clear = 1'b0;
      total++;
      if (AssistState !== OFF || n < 16) begin
         bad++;
         $display("FAIL pitch_exit: got st=%0d after %0d clks required %0d after >=16", AssistState, n, OFF);
      end
      n = 0;
      while (AssistState != RAMP_UP && n < 8) begin
         next_tick();
         n++;
      end
      next_tick();
      total++;
      if (AssistState !== RAMP_UP || MotorCommand !== 13'd16) begin
         bad++;
         $display("FAIL ramp_restart: got st=%0d cmd=%0d required %0d/16", AssistState, MotorCommand, RAMP_UP);
      end
      #3 reset = 1'b1;
      #1;
      total++;
      if (MotorCommand !== 13'd0 || AssistState !== OFF || MotorEnable !== 1'b0 || fault !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: got cmd=%0d st=%0d en=%0b fault=%0b required 0/%0d/0/0",
                  MotorCommand, AssistState, MotorEnable, fault, OFF);
      end
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, required earlier finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_ramp_up();
      test_track();
      test_brake();
      test_tilt();
      test_cadence_loss();
      test_pitch_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
